// File: rtl/lsu_mem_stage_pkg.sv
// Shared types for the load/store memory stage: memory op encoding, FSM states,
// pipeline bus layout and store lane helpers.
package core;

  localparam int   MEM_OP_BITS = 4;
  localparam logic STORE_PRFX  = 1'b1;

  typedef enum logic [MEM_OP_BITS-1:0] {
    LB      = 4'b0000,
    LH      = 4'b0001,
    LW      = 4'b0010,
    LBU     = 4'b0100,
    LHU     = 4'b0101,
    MEM_NOP = 4'b0111,
    SB      = 4'b1000,
    SH      = 4'b1001,
    SW      = 4'b1010
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } lsu_state_t;

  typedef struct packed {
    mem_op_t     mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic [4:0]  rd;
    logic [31:0] rd_res;
    logic        rf_wr_en;
    logic        mem_w_en;
  } pipeline_bus_t;

  function automatic logic [3:0] lane_be(input mem_op_t op, input logic [1:0] a);
    case (op)
      LB, LBU, SB: lane_be = 4'b0001 << a;
      LH, LHU, SH: lane_be = 4'b0011 << {a[1], 1'b0};
      default:     lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input mem_op_t op, input logic [31:0] d);
    case (op)
      SB:      store_wdata = {4{d[7:0]}};
      SH:      store_wdata = {2{d[15:0]}};
      SW:      store_wdata = d;
      default: store_wdata = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic misaligned(input mem_op_t op, input logic [1:0] a);
    case (op)
      LH, LHU, SH: misaligned = a[0];
      LW, SW:      misaligned = (a != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Combinational load data alignment: selects the addressed byte/halfword of the
// returned word and sign- or zero-extends it according to the load type.
module lsu_load_align
  import core::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  mem_op_t     i_mem_op,
  output logic [31:0] o_result
);

  logic [1:0]  w_shamt;
  logic [31:0] w_word;

  // Lane select then extension
  always_comb begin
    w_shamt = 2'b00;
    case (i_mem_op)
      LB, LBU: w_shamt = i_addr_lo;
      LH, LHU: w_shamt = {i_addr_lo[1], 1'b0};
      default: w_shamt = 2'b00;
    endcase
    w_word = i_rdata >> {w_shamt, 3'b000};
    case (i_mem_op)
      LB:      o_result = {{24{w_word[7]}}, w_word[7:0]};
      LBU:     o_result = {24'h00_0000, w_word[7:0]};
      LH:      o_result = {{16{w_word[15]}}, w_word[15:0]};
      LHU:     o_result = {16'h0000, w_word[15:0]};
      default: o_result = w_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage / load-store unit with a req/gnt/rvalid data port and response timeout.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage
  import core::*;
#(
  parameter int unsigned RSP_TIMEOUT = 256,
  parameter bit          STORE_ACK   = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  pipeline_bus_t mem_bus_i,
  input  logic          mem_valid_i,
  output logic          mem_ready_o,
  output logic          stall_o,
  output pipeline_bus_t mem_bus_o,
  output logic          mem_valid_o,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [31:0]   dmem_addr_o,
  output logic [3:0]    dmem_be_o,
  output logic [31:0]   dmem_wdata_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [31:0]   dmem_rdata_i,
  output logic          bus_err_o,
  output logic          misalign_o
);

  localparam logic [31:0] TMO_LIM = 32'(RSP_TIMEOUT);

  lsu_state_t    r_state;
  lsu_state_t    w_state_nxt;
  pipeline_bus_t r_bus;
  pipeline_bus_t r_bus_o;
  pipeline_bus_t w_emit_bus;
  logic [31:0]   r_tmo_cnt;
  logic [31:0]   w_cnt_nxt;
  logic [31:0]   w_cnt_inc;
  logic          r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [31:0]   r_addr;
  logic          r_valid_o;
  logic          r_bus_err;
  logic          r_misalign;
  logic          w_emit;
  logic          w_err;
  logic          w_mis;
  logic          w_latch;
  logic          w_misalign_in;
  logic          w_lat_store;
  logic          w_in_store;
  logic [31:0]   w_load_data;

  lsu_load_align u_load_align (
    .i_rdata   (dmem_rdata_i),
    .i_addr_lo (r_bus.mem_addr[1:0]),
    .i_mem_op  (r_bus.mem_op),
    .o_result  (w_load_data)
  );

  assign w_in_store  = (mem_bus_i.mem_op[MEM_OP_BITS-1] == STORE_PRFX);
  assign w_lat_store = (r_bus.mem_op[MEM_OP_BITS-1] == STORE_PRFX);
  assign w_cnt_inc   = r_tmo_cnt + 32'd1;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign_in = misaligned(mem_bus_i.mem_op, mem_bus_i.mem_addr[1:0]);
`else
  assign w_misalign_in = 1'b0;
`endif

  assign mem_ready_o  = (r_state == IDLE);
  assign stall_o      = (r_state != IDLE) | (mem_valid_i & (mem_bus_i.mem_op != MEM_NOP));
  assign dmem_req_o   = (r_state == REQ);
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;
  assign mem_bus_o    = r_bus_o;
  assign mem_valid_o  = r_valid_o;
  assign bus_err_o    = r_bus_err;
  assign misalign_o   = r_misalign;

  // Next-state and emit decisions
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_err       = 1'b0;
    w_mis       = 1'b0;
    w_latch     = 1'b0;
    w_emit_bus  = r_bus;
    w_cnt_nxt   = r_tmo_cnt;
    case (r_state)
      IDLE: begin
        if (mem_valid_i && (mem_bus_i.mem_op == MEM_NOP)) begin
          w_emit     = 1'b1;
          w_emit_bus = mem_bus_i;
        end else if (mem_valid_i && w_misalign_in) begin
          w_emit              = 1'b1;
          w_mis               = 1'b1;
          w_emit_bus          = mem_bus_i;
          w_emit_bus.rf_wr_en = 1'b0;
          w_emit_bus.mem_w_en = 1'b0;
        end else if (mem_valid_i) begin
          w_latch     = 1'b1;
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        if (dmem_gnt_i && w_lat_store && !STORE_ACK) begin
          w_emit              = 1'b1;
          w_emit_bus.rf_wr_en = 1'b0;
          w_emit_bus.mem_w_en = 1'b1;
          w_state_nxt         = IDLE;
        end else if (dmem_gnt_i) begin
          w_cnt_nxt   = 32'd0;
          w_state_nxt = WAIT_RSP;
        end else begin
          w_state_nxt = REQ;
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid_i) begin
          w_emit      = 1'b1;
          w_state_nxt = IDLE;
          if (w_lat_store) begin
            w_emit_bus.rf_wr_en = 1'b0;
            w_emit_bus.mem_w_en = 1'b1;
          end else begin
            w_emit_bus.rd_res   = w_load_data;
            w_emit_bus.mem_w_en = 1'b0;
          end
        end else if ((TMO_LIM != 32'd0) && (w_cnt_inc == TMO_LIM)) begin
          // Response never came: retire without writing anything back
          w_emit              = 1'b1;
          w_err               = 1'b1;
          w_emit_bus.rd_res   = 32'h0000_0000;
          w_emit_bus.rf_wr_en = 1'b0;
          w_emit_bus.mem_w_en = 1'b0;
          w_state_nxt         = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, request latch and registered writeback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bus      <= '0;
      r_bus_o    <= '0;
      r_tmo_cnt  <= 32'd0;
      r_we       <= 1'b0;
      r_be       <= 4'h0;
      r_wdata    <= 32'h0000_0000;
      r_addr     <= 32'h0000_0000;
      r_valid_o  <= 1'b0;
      r_bus_err  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmo_cnt  <= w_cnt_nxt;
      r_valid_o  <= w_emit;
      r_bus_err  <= w_err;
      r_misalign <= w_mis;
      if (w_emit) begin
        r_bus_o <= w_emit_bus;
      end
      if (w_latch) begin
        r_bus   <= mem_bus_i;
        r_addr  <= {mem_bus_i.mem_addr[31:2], 2'b00};
        r_we    <= w_in_store;
        r_be    <= lane_be(mem_bus_i.mem_op, mem_bus_i.mem_addr[1:0]);
        r_wdata <= store_wdata(mem_bus_i.mem_op, mem_bus_i.mem_w_data);
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage (RSP_TIMEOUT=4, STORE_ACK=0); covers
// LSU_MISALIGN_TRAP_EN in both builds.
module tb_lsu_mem_stage;
  import core::*;

  typedef struct {
    logic [31:0] res;
    logic        chk_res;
    logic        rfw;
    logic        wen;
    logic [4:0]  rd;
    logic        err;
    logic        mis;
    int          t0;
    int          lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  pipeline_bus_t bus_in = '0;
  logic          valid_in = 1'b0;
  logic          mem_ready_o, stall_o, mem_valid_o;
  pipeline_bus_t mem_bus_o;
  logic          dmem_req_o, dmem_we_o;
  logic [31:0]   dmem_addr_o, dmem_wdata_o;
  logic [3:0]    dmem_be_o;
  logic          gnt = 1'b0;
  logic          rvalid = 1'b0;
  logic [31:0]   rdata = 32'h0000_0000;
  logic          bus_err_o, misalign_o;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_t0 = 0;

  lsu_mem_stage #(.RSP_TIMEOUT(4), .STORE_ACK(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_bus_i(bus_in), .mem_valid_i(valid_in),
    .mem_ready_o(mem_ready_o), .stall_o(stall_o), .mem_bus_o(mem_bus_o),
    .mem_valid_o(mem_valid_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .bus_err_o(bus_err_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input mem_op_t op, input logic [1:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = (a == 2'd0) ? d[7:0] : (a == 2'd1) ? d[15:8] : (a == 2'd2) ? d[23:16] : d[31:24];
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'd0, b};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'd0, h};
      default: return d;
    endcase
  endfunction

  task automatic push(input logic [31:0] res, input logic chk_res, input logic rfw, input logic wen,
                      input logic [4:0] rd, input logic err, input logic mis, input int lat);
    exp_t e;
    e.res = res; e.chk_res = chk_res; e.rfw = rfw; e.wen = wen; e.rd = rd;
    e.err = err; e.mis = mis; e.t0 = last_t0; e.lat = lat;
    sb.push_back(e);
  endtask

  // Called just after a posedge; returns just after the accepting edge
  task automatic drive_op(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input logic rfw, input logic [31:0] res);
    last_t0 = cyc;
    bus_in.mem_op = op; bus_in.mem_addr = a; bus_in.mem_w_data = wd; bus_in.rd = rd;
    bus_in.rd_res = res; bus_in.rf_wr_en = rfw; bus_in.mem_w_en = 1'b0;
    valid_in = 1'b1;
    #1;
    check_val("ready_on_accept", mem_ready_o, 1);
    check_val("stall_on_accept", stall_o, (op != MEM_NOP));
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  // Holds gnt low for 'hold' cycles, checking the request each cycle, then grants
  task automatic grant(input int hold, input logic [31:0] ea, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic ewe);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      check_val("req", dmem_req_o, 1);
      check_val("addr", dmem_addr_o, ea);
      check_val("be", dmem_be_o, ebe);
      check_val("we", dmem_we_o, ewe);
      if (ewe) check_val("wdata", dmem_wdata_o, ewd);
      check_val("ready_busy", mem_ready_o, 0);
      check_val("stall_busy", stall_o, 1);
      if (i == hold) gnt = 1'b1;
    end
    @(posedge clk); #1;
    gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    rvalid = 1'b1;
    rdata = d;
    @(posedge clk); #1;
    rvalid = 1'b0;
    rdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_val("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Output monitor: every mem_valid_o pulse must match the oldest expectation
  always @(negedge clk) begin
    if (mem_valid_o) begin
      if (sb.size() == 0) begin
        check_val("unexpected_valid", {31'd0, mem_valid_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_res) check_val("rd_res", mem_bus_o.rd_res, e.res);
        check_val("rf_wr_en", mem_bus_o.rf_wr_en, e.rfw);
        check_val("mem_w_en", mem_bus_o.mem_w_en, e.wen);
        check_val("rd", mem_bus_o.rd, e.rd);
        check_val("bus_err", bus_err_o, e.err);
        check_val("misalign", misalign_o, e.mis);
        if (e.lat >= 0) check_val("latency", cyc - e.t0, e.lat);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", mem_valid_o, 0);
    check_val("rst_req", dmem_req_o, 0);
    check_val("rst_bus", {31'd0, |mem_bus_o}, 0);
    check_val("rst_err", bus_err_o, 0);
    check_val("rst_ready", mem_ready_o, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Non-memory pass-through, latency 1
    drive_op(MEM_NOP, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_55AA);
    push(32'h0000_55AA, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1);
    drain();

    // LW with immediate grant and next-cycle response, latency 3
    drive_op(LW, 32'h100, 32'h0, 5'd1, 1'b1, 32'h0);
    push(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 3);
    grant(0, 32'h100, 4'hF, 32'h0, 1'b0);
    respond(32'hDEAD_BEEF);
    drain();

    // Signed and unsigned byte loads from the top lane
    drive_op(LB, 32'h103, 32'h0, 5'd2, 1'b1, 32'h0);
    push(exp_load(LB, 2'd3, 32'h8000_0000), 1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 3);
    grant(0, 32'h100, 4'b1000, 32'h0, 1'b0);
    respond(32'h8000_0000);
    drain();
    drive_op(LBU, 32'h103, 32'h0, 5'd4, 1'b1, 32'h0);
    push(exp_load(LBU, 2'd3, 32'h8000_0000), 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 3);
    grant(0, 32'h100, 4'b1000, 32'h0, 1'b0);
    respond(32'h8000_0000);
    drain();

    // Stores retire on grant with lane-replicated data
    drive_op(SH, 32'h202, 32'h1234_ABCD, 5'd5, 1'b1, 32'h0);
    push(32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 2);
    grant(0, 32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1);
    drain();
    drive_op(SB, 32'h201, 32'h0000_00EF, 5'd6, 1'b1, 32'h0);
    push(32'h0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 2);
    grant(0, 32'h200, 4'b0010, 32'hEFEF_EFEF, 1'b1);
    drain();
    drive_op(SW, 32'h204, 32'hA5A5_0F0F, 5'd7, 1'b0, 32'h0);
    push(32'h0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 2);
    grant(0, 32'h204, 4'hF, 32'hA5A5_0F0F, 1'b1);
    drain();

    // Grant withheld for 3 cycles on a halfword load
    drive_op(LH, 32'h106, 32'h0, 5'd8, 1'b1, 32'h0);
    push(exp_load(LH, 2'd2, 32'h8001_0000), 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 6);
    grant(3, 32'h104, 4'b1100, 32'h0, 1'b0);
    respond(32'h8001_0000);
    drain();
    drive_op(LHU, 32'h100, 32'h0, 5'd9, 1'b1, 32'h0);
    push(exp_load(LHU, 2'd0, 32'h1234_F00D), 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 3);
    grant(0, 32'h100, 4'b0011, 32'h0, 1'b0);
    respond(32'h1234_F00D);
    drain();

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    drive_op(LW, 32'h101, 32'h0, 5'd10, 1'b1, 32'h0);
    push(32'h0, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("mis_no_req", dmem_req_o, 0);
    end
    drain();
`else
    drive_op(LW, 32'h101, 32'h0, 5'd10, 1'b1, 32'h0);
    push(32'h1122_3344, 1'b1, 1'b1, 1'b0, 5'd10, 1'b0, 1'b0, 3);
    grant(0, 32'h100, 4'hF, 32'h0, 1'b0);
    respond(32'h1122_3344);
    drain();
`endif

    // Response timeout after 4 cycles in WAIT_RSP
    drive_op(LW, 32'h300, 32'h0, 5'd11, 1'b1, 32'h0);
    push(32'h0, 1'b1, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0, -1);
    grant(0, 32'h300, 4'hF, 32'h0, 1'b0);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus_err_o) break;
    end
    check_val("tmo_cycles", n, 4);
    @(posedge clk); #1;
    respond(32'h7777_7777);
    drain();

    // Reset while waiting for a response; later rvalid must be ignored
    drive_op(LW, 32'h400, 32'h0, 5'd12, 1'b1, 32'h0);
    grant(0, 32'h400, 4'hF, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("rstw_req", dmem_req_o, 0);
    check_val("rstw_valid", mem_valid_o, 0);
    check_val("rstw_ready", mem_ready_o, 1);
    check_val("rstw_stall", stall_o, 0);
    check_val("rstw_bus", {31'd0, |mem_bus_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    respond(32'hCAFE_F00D);
    repeat (3) @(negedge clk);
    check_val("rstw_idle", mem_ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
